// File: rtl/seg_frame_pkg.sv
// Shared constants, state encoding and frame-slice helper for the
// seven-segment serial frame transmitter.
package seg_frame_pkg;

    localparam int unsigned FRAME_BITS  = 96;
    localparam int unsigned BRIGHT_BITS = 8;
    localparam int unsigned SHREG_BITS  = FRAME_BITS + BRIGHT_BITS;
    localparam int unsigned NUM_DIGITS  = 4;
    localparam int unsigned SLICE_BITS  = 24;

    // Bit offsets inside one 24-bit digit slice
    localparam int unsigned RED_LSB = 16;
    localparam int unsigned GRN_LSB = 8;
    localparam int unsigned AN_LSB  = 0;

    typedef enum logic [1:0] {
        COL_OFF = 2'b00,
        COL_RED = 2'b01,
        COL_GRN = 2'b10,
        COL_AMB = 2'b11
    } colour_e;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_SHIFT  = 3'd2;
    localparam logic [2:0] ST_LATCH  = 3'd3;
    localparam logic [2:0] ST_BSHIFT = 3'd4;
    localparam logic [2:0] ST_PWM    = 3'd5;

    function automatic logic [SLICE_BITS-1:0] build_slice(input logic [6:0] seg,
                                                         input logic [1:0] col,
                                                         input logic [5:0] mask);
        logic [SLICE_BITS-1:0] s;
        s = '0;
        s[RED_LSB +: 7] = seg & {7{col[0]}};
        s[GRN_LSB +: 7] = seg & {7{col[1]}};
        s[AN_LSB  +: 6] = (col == COL_OFF) ? 6'd0 : mask;
        return s;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex digit to seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module seg7_hex_decode (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        case (hex)
            4'h0:    seg = 7'b0111111;
            4'h1:    seg = 7'b0000110;
            4'h2:    seg = 7'b1011011;
            4'h3:    seg = 7'b1001111;
            4'h4:    seg = 7'b1100110;
            4'h5:    seg = 7'b1101101;
            4'h6:    seg = 7'b1111101;
            4'h7:    seg = 7'b0000111;
            4'h8:    seg = 7'b1111111;
            4'h9:    seg = 7'b1101111;
            4'hA:    seg = 7'b1110111;
            4'hB:    seg = 7'b1111100;
            4'hC:    seg = 7'b0111001;
            4'hD:    seg = 7'b1011110;
            4'hE:    seg = 7'b1111001;
            default: seg = 7'b1110001;
        endcase
    end

endmodule

// File: rtl/seg_frame_tx.sv
// Serialises four coloured hex digits plus a brightness byte into the
// shift/latch/pwm-load protocol of the bi-colour seven-segment driver.
module seg_frame_tx
    import seg_frame_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 4,
    parameter logic [5:0]  LED_MASK = 6'h3F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] digit,
    input  logic [7:0]  color,
    input  logic [7:0]  bright,
    output logic        busy,
    output logic        done,
    output logic        ser_clk,
    output logic        ser_data,
    output logic        ser_latch,
    output logic        ser_pwm
);

    localparam int unsigned PH_W = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
    localparam logic [PH_W-1:0] PH_HALF = PH_W'(CLK_DIV);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * CLK_DIV - 1);

    logic [6:0]            seg [NUM_DIGITS];
    logic [FRAME_BITS-1:0] frame;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        seg7_hex_decode u_dec (
            .hex (digit[4*i +: 4]),
            .seg (seg[i])
        );
        assign frame[SLICE_BITS*i +: SLICE_BITS] = build_slice(seg[i], color[2*i +: 2], LED_MASK);
    end

    logic [2:0]            state_q, state_d;
    logic [PH_W-1:0]       ph_q, ph_d;
    logic [6:0]            cnt_q, cnt_d;
    logic [SHREG_BITS-1:0] shreg_q, shreg_d;
    logic                  pending_q, pending_d;
    logic                  phase_end;

    assign phase_end = (ph_q == PH_LAST);

    always_comb begin
        state_d   = state_q;
        ph_d      = phase_end ? '0 : ph_q + 1'b1;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        pending_d = pending_q | start;
        case (state_q)
            ST_IDLE: begin
                ph_d      = '0;
                pending_d = 1'b0;
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                // Brightness rides behind the frame so one register feeds both shift phases
                shreg_d = {frame, bright};
                cnt_d   = 7'(FRAME_BITS - 1);
                ph_d    = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT, ST_BSHIFT: begin
                if (phase_end) begin
                    shreg_d = {shreg_q[SHREG_BITS-2:0], 1'b0};
                    cnt_d   = cnt_q - 7'd1;
                    if (cnt_q == 7'd0) state_d = (state_q == ST_SHIFT) ? ST_LATCH : ST_PWM;
                end
            end
            ST_LATCH: begin
                if (phase_end) begin
                    cnt_d   = 7'(BRIGHT_BITS - 1);
                    state_d = ST_BSHIFT;
                end
            end
            ST_PWM: begin
                if (phase_end) begin
                    pending_d = 1'b0;
                    state_d   = (pending_q || start) ? ST_LOAD : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ph_q      <= '0;
            cnt_q     <= '0;
            shreg_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            pending_q <= pending_d;
        end
    end

    logic shifting;
    assign shifting = (state_q == ST_SHIFT) || (state_q == ST_BSHIFT);

    always_comb begin
        done      = (state_q == ST_PWM) && phase_end;
        // A queued or coincident start keeps busy high through the done cycle
        busy      = (state_q != ST_IDLE) && !(done && !pending_q && !start);
        ser_clk   = shifting && (ph_q >= PH_HALF);
        ser_data  = shifting && shreg_q[SHREG_BITS-1];
        ser_latch = (state_q == ST_LATCH) && (ph_q < PH_HALF);
        ser_pwm   = (state_q == ST_PWM) && (ph_q < PH_HALF);
    end

endmodule

// File: tb/tb_seg_frame_tx.sv
// Directed bench for seg_frame_tx with a small display-driver receive model.
module tb_seg_frame_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] digit = '0;
    logic [7:0]  color = '0;
    logic [7:0]  bright = '0;
    logic        busy, done, ser_clk, ser_data, ser_latch, ser_pwm;

    int checks = 0;
    int errors = 0;

    seg_frame_tx #(
        .CLK_DIV  (4),
        .LED_MASK (6'h3F)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .digit     (digit),
        .color     (color),
        .bright    (bright),
        .busy      (busy),
        .done      (done),
        .ser_clk   (ser_clk),
        .ser_data  (ser_data),
        .ser_latch (ser_latch),
        .ser_pwm   (ser_pwm)
    );

    always #5 clk = ~clk;

    // Driver receive model and protocol monitors
    int          cyc = 0;
    int          bits_total = 0;
    int          latch_cnt = 0;
    int          pwm_cnt = 0;
    int          latch_at = 0;
    int          pwm_at = 0;
    int          overlap = 0;
    int          unstable = 0;
    int          done_cnt = 0;
    logic [95:0] drv_sreg = '0;
    logic [95:0] drv_disp = '0;
    logic [7:0]  drv_bright = '0;
    logic        prev_clk = 1'b0;
    logic        prev_latch = 1'b0;
    logic        prev_pwm = 1'b0;
    logic        prev_data = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ser_clk && !prev_clk) begin
            if (ser_data !== prev_data) unstable <= unstable + 1;
            drv_sreg   <= {drv_sreg[94:0], ser_data};
            bits_total <= bits_total + 1;
        end
        if (ser_latch && !prev_latch) begin
            latch_cnt <= latch_cnt + 1;
            latch_at  <= bits_total;
            drv_disp  <= drv_sreg;
        end
        if (ser_pwm && !prev_pwm) begin
            pwm_cnt    <= pwm_cnt + 1;
            pwm_at     <= bits_total;
            drv_bright <= drv_sreg[7:0];
        end
        if (int'(ser_clk) + int'(ser_latch) + int'(ser_pwm) > 1) overlap <= overlap + 1;
        if (done) done_cnt <= done_cnt + 1;
        prev_clk   <= ser_clk;
        prev_latch <= ser_latch;
        prev_pwm   <= ser_pwm;
        prev_data  <= ser_data;
    end

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    int t_start = 0;

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t_start = cyc;
    endtask

    task automatic wait_done(output int t_done, output int lows);
        int n;
        n = 0;
        lows = 0;
        while (done !== 1'b1 && n < 4000) begin
            if (busy !== 1'b1) lows++;
            @(negedge clk);
            n++;
        end
        t_done = cyc;
    endtask

    // Starts one transaction and checks it; returns during the done cycle
    task automatic run_frame(input string tag, input logic [95:0] exp_frame,
                             input logic [7:0] exp_bright);
        int base, t_done, lows;
        base = bits_total;
        pulse_start();
        check({tag, "_busy_load"}, 96'(busy), 96'(1));
        wait_done(t_done, lows);
        check({tag, "_done"}, 96'(done), 96'(1));
        check({tag, "_latency"}, 96'(t_done - t_start + 1), 96'(849));
        check({tag, "_busy_gap"}, 96'(lows), 96'(0));
        check({tag, "_done_busy"}, 96'({busy, ser_data}), 96'(0));
        check({tag, "_frame"}, drv_disp, exp_frame);
        check({tag, "_bright"}, 96'(drv_bright), 96'(exp_bright));
        check({tag, "_latch_pos"}, 96'(latch_at - base), 96'(96));
        check({tag, "_pwm_pos"}, 96'(pwm_at - base), 96'(104));
    endtask

    function automatic logic [95:0] all_outs();
        return 96'({busy, done, ser_clk, ser_data, ser_latch, ser_pwm});
    endfunction

    localparam logic [95:0] EXP_RED1  = {24'h06003F, 72'h0};
    localparam logic [95:0] EXP_AMB8  = {4{24'h7F7F3F}};
    localparam logic [95:0] EXP_HEX   = {24'h005E3F, 24'h00393F, 24'h007C3F, 24'h00773F};
    localparam logic [95:0] EXP_PEND1 = {24'h66663F, 24'h004F3F, 24'h5B003F, 24'h000000};
    localparam logic [95:0] EXP_PEND2 = {24'h79003F, 24'h6D003F, 24'h00713F, 24'h3F3F3F};
    localparam logic [95:0] EXP_ABORT = {24'h000000, 24'h07073F, 24'h7D003F, 24'h005B3F};

    initial begin
        int t0, t1, t2, lows, dc0, lc0, pc0;

        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 96'(0));
        rst = 1'b0;
        @(negedge clk);
        check("idle_outputs", all_outs(), 96'(0));

        digit = 16'h1000; color = 8'b01_00_00_00; bright = 8'h80;
        run_frame("red1", EXP_RED1, 8'h80);
        @(negedge clk);
        check("red1_done_pulse", 96'({done, busy}), 96'(0));

        digit = 16'h8888; color = 8'hFF; bright = 8'h40;
        run_frame("amb8", EXP_AMB8, 8'h40);
        for (int i = 0; i < 4; i++)
            check("amb8_active_outs", 96'($countones(drv_disp[24*i +: 24])), 96'(20));

        digit = 16'hDCBA; color = 8'hAA; bright = 8'hFF;
        run_frame("hex", EXP_HEX, 8'hFF);

        // Pending merge: one queued start plus two merged ones, inputs changed mid-flight
        repeat (3) @(negedge clk);
        dc0 = done_cnt;
        digit = 16'h4321; color = 8'b11_10_01_00; bright = 8'h11;
        pulse_start();
        t0 = t_start;
        repeat (10) @(negedge clk);
        digit = 16'hE5F0; color = 8'b01_01_10_11; bright = 8'hC3;
        pulse_start();
        repeat (200) @(negedge clk);
        pulse_start();
        pulse_start();
        wait_done(t1, lows);
        check("pend_first_lat", 96'(t1 - t0 + 1), 96'(849));
        check("pend_busy_hold", 96'(busy), 96'(1));
        check("pend_frame1", drv_disp, EXP_PEND1);
        check("pend_bright1", 96'(drv_bright), 96'(8'h11));
        @(negedge clk);
        wait_done(t2, lows);
        check("pend_second_lat", 96'(t2 - t1), 96'(849));
        check("pend_busy_gap", 96'(lows), 96'(0));
        check("pend_frame2", drv_disp, EXP_PEND2);
        check("pend_bright2", 96'(drv_bright), 96'(8'hC3));
        repeat (1000) @(negedge clk);
        check("pend_txn_count", 96'(done_cnt - dc0), 96'(2));
        check("pend_idle", 96'(busy), 96'(0));

        // Abort at cycle 300; a start coincident with rst must be ignored
        lc0 = latch_cnt;
        pc0 = pwm_cnt;
        pulse_start();
        t0 = t_start;
        while (cyc - t0 + 1 < 300) @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        check("abort_outputs", all_outs(), 96'(0));
        repeat (1000) @(negedge clk);
        check("abort_no_latch", 96'(latch_cnt - lc0), 96'(0));
        check("abort_no_pwm", 96'(pwm_cnt - pc0), 96'(0));
        check("abort_idle", 96'(busy), 96'(0));
        digit = 16'h9762; color = 8'b00_11_01_10; bright = 8'h5A;
        run_frame("abort_new", EXP_ABORT, 8'h5A);

        // Start coincident with done and no pending request
        start = 1'b1;
        #1;
        check("done_start_busy", 96'(busy), 96'(1));
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
        check("done_start_load", 96'(busy), 96'(1));
        wait_done(t1, lows);
        check("done_start_lat", 96'(t1 - t0 + 1), 96'(849));
        check("done_start_frame", drv_disp, EXP_ABORT);

        check("excl_strobes", 96'(overlap), 96'(0));
        check("data_stable", 96'(unstable), 96'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
